// File: rtl/key_input_conditioner.sv
// Pushbutton conditioner: 2-flop sync, debounce, short/long press classification with sticky acked flags.
// keys_stable lags a clean raw edge by DEBOUNCE_CYCLES+2 edges; flags hold until event_ack. KEYIN_REPEAT_EN adds auto-repeat.
module key_input_conditioner #(
   parameter int          NUM_KEYS        = 2,
   parameter bit          ACTIVE_LOW      = 1'b1,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 50000000,
   parameter int unsigned REPEAT_CYCLES   = 10000000
) (
   input  logic                nReset,
   input  logic                clock,
   input  logic [NUM_KEYS-1:0] keys_raw,
   output logic [NUM_KEYS-1:0] keys_stable,
   output logic [NUM_KEYS-1:0] short_pending,
   output logic [NUM_KEYS-1:0] long_pending,
   input  logic [NUM_KEYS-1:0] event_ack,
   output logic [NUM_KEYS-1:0] repeat_pulse
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } press_state_t;

   localparam logic [NUM_KEYS-1:0] RELEASED_LVL = {NUM_KEYS{ACTIVE_LOW}};
   localparam logic [31:0]         DEB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
   localparam logic [31:0]         LONG_LAST    = 32'(LONG_CYCLES - 1);

   generate
      if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES == 0) begin : g_param_check
         $error("key_input_conditioner: inconsistent cycle parameters");
      end
   endgenerate

   logic [NUM_KEYS-1:0] sync1_q, sync1_d;
   logic [NUM_KEYS-1:0] sync2_q, sync2_d;
   logic [NUM_KEYS-1:0] stable_q, stable_d;
   logic [NUM_KEYS-1:0] short_q, short_d;
   logic [NUM_KEYS-1:0] long_q, long_d;
   logic [31:0]         deb_cnt_q [NUM_KEYS];
   logic [31:0]         deb_cnt_d [NUM_KEYS];
   logic [31:0]         hold_q    [NUM_KEYS];
   logic [31:0]         hold_d    [NUM_KEYS];
   press_state_t        state_q   [NUM_KEYS];
   press_state_t        state_d   [NUM_KEYS];
   logic [NUM_KEYS-1:0] sync_n;
   logic [NUM_KEYS-1:0] rise;
`ifdef KEYIN_REPEAT_EN
   localparam logic [31:0] REP_LAST = 32'(REPEAT_CYCLES - 1);
   logic [NUM_KEYS-1:0] rep_q, rep_d;
`endif

   // Normalise after the second flop so everything downstream sees 1 = pressed.
   assign sync_n = sync2_q ^ {NUM_KEYS{ACTIVE_LOW}};

   always_comb begin
      sync1_d  = keys_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      short_d  = short_q & ~event_ack;
      long_d   = long_q & ~event_ack;
      rise     = '0;
`ifdef KEYIN_REPEAT_EN
      rep_d    = '0;
`endif
      for (int k = 0; k < NUM_KEYS; k++) begin
         deb_cnt_d[k] = '0;
         hold_d[k]    = hold_q[k];
         state_d[k]   = state_q[k];

         if (sync_n[k] != stable_q[k]) begin
            if (deb_cnt_q[k] == DEB_LAST) begin
               stable_d[k] = sync_n[k];
               rise[k]     = sync_n[k];
            end else begin
               deb_cnt_d[k] = deb_cnt_q[k] + 32'd1;
            end
         end

         // Entry uses the debounce decision itself so the hold count starts with the stable edge.
         case (state_q[k])
            IDLE: begin
               if (rise[k]) begin
                  state_d[k] = PRESSED;
                  hold_d[k]  = '0;
               end
            end
            PRESSED: begin
               if (!stable_q[k]) begin
                  short_d[k] = 1'b1;
                  state_d[k] = IDLE;
               end else if (hold_q[k] == LONG_LAST) begin
                  long_d[k]  = 1'b1;
                  state_d[k] = LONG_HELD;
                  hold_d[k]  = '0;
               end else begin
                  hold_d[k] = hold_q[k] + 32'd1;
               end
            end
            LONG_HELD: begin
               if (!stable_q[k]) begin
                  state_d[k] = IDLE;
`ifdef KEYIN_REPEAT_EN
               end else if (hold_q[k] == REP_LAST) begin
                  rep_d[k]  = 1'b1;
                  hold_d[k] = '0;
               end else begin
                  hold_d[k] = hold_q[k] + 32'd1;
`endif
               end
            end
            default: begin
               state_d[k] = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         sync1_q  <= RELEASED_LVL;
         sync2_q  <= RELEASED_LVL;
         stable_q <= '0;
         short_q  <= '0;
         long_q   <= '0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            deb_cnt_q[k] <= '0;
            hold_q[k]    <= '0;
            state_q[k]   <= IDLE;
         end
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         short_q  <= short_d;
         long_q   <= long_d;
         for (int k = 0; k < NUM_KEYS; k++) begin
            deb_cnt_q[k] <= deb_cnt_d[k];
            hold_q[k]    <= hold_d[k];
            state_q[k]   <= state_d[k];
         end
      end
   end

`ifdef KEYIN_REPEAT_EN
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         rep_q <= '0;
      end else begin
         rep_q <= rep_d;
      end
   end

   assign repeat_pulse = rep_q;
`else
   assign repeat_pulse = '0;
`endif

   assign keys_stable   = stable_q;
   assign short_pending = short_q;
   assign long_pending  = long_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner: directed test-plan steps plus random key/ack traffic against a press-age model.
module tb_key_input_conditioner;

   localparam int NK = 2;
   localparam int D  = 8;
   localparam int L  = 32;
   localparam int R  = 16;
`ifdef KEYIN_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          nReset = 1'b0;
   logic [NK-1:0] keys_raw = 2'b11;
   logic [NK-1:0] event_ack = 2'b00;
   logic [NK-1:0] keys_stable, short_pending, long_pending, repeat_pulse;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   key_input_conditioner #(
      .NUM_KEYS(NK), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES(L), .REPEAT_CYCLES(R)
   ) dut (
      .nReset(nReset), .clock(clock), .keys_raw(keys_raw),
      .keys_stable(keys_stable), .short_pending(short_pending),
      .long_pending(long_pending), .event_ack(event_ack),
      .repeat_pulse(repeat_pulse)
   );

   // Reference: synchronised level, debounce run length, and age of the current press in edges.
   bit m_s1 [NK], m_s2 [NK], m_stable [NK], m_in_press [NK];
   bit m_short [NK], m_long [NK], m_rep [NK];
   int m_run [NK], m_age [NK];

   always @(posedge clock or negedge nReset) begin : ref_model
      bit s_set, l_set;
      if (!nReset) begin
         for (int k = 0; k < NK; k++) begin
            m_s1[k] = 0; m_s2[k] = 0; m_stable[k] = 0; m_in_press[k] = 0;
            m_short[k] = 0; m_long[k] = 0; m_rep[k] = 0; m_run[k] = 0; m_age[k] = 0;
         end
      end else begin
         for (int k = 0; k < NK; k++) begin
            s_set = 0;
            l_set = 0;
            m_rep[k] = 0;
            if (m_in_press[k]) begin
               if (!m_stable[k]) begin
                  m_in_press[k] = 0;
                  if (m_age[k] < L) s_set = 1;
               end else begin
                  m_age[k]++;
                  if (m_age[k] == L) l_set = 1;
                  if (REP_EN && m_age[k] > L && ((m_age[k] - L) % R) == 0) m_rep[k] = 1;
               end
            end
            if (m_s2[k] != m_stable[k]) begin
               m_run[k]++;
               if (m_run[k] == D) begin
                  m_stable[k] = m_s2[k];
                  m_run[k] = 0;
                  if (m_stable[k]) begin
                     m_in_press[k] = 1;
                     m_age[k] = 0;
                  end
               end
            end else begin
               m_run[k] = 0;
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = ~keys_raw[k];
            m_short[k] = s_set | (m_short[k] & ~event_ack[k]);
            m_long[k]  = l_set | (m_long[k] & ~event_ack[k]);
         end
      end
   end

   task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic compare_model();
      logic [NK-1:0] es, ss, ls, rs;
      for (int k = 0; k < NK; k++) begin
         es[k] = m_stable[k];
         ss[k] = m_short[k];
         ls[k] = m_long[k];
         rs[k] = m_rep[k];
      end
      chk("model_keys_stable", keys_stable, es);
      chk("model_short_pending", short_pending, ss);
      chk("model_long_pending", long_pending, ls);
      chk("model_repeat_pulse", repeat_pulse, rs);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
         compare_model();
      end
   endtask

   initial begin
      // Reset state
      tick(3);
      chk("rst_stable", keys_stable, 2'b00);
      chk("rst_short", short_pending, 2'b00);
      chk("rst_long", long_pending, 2'b00);
      chk("rst_repeat", repeat_pulse, 2'b00);
      nReset = 1'b1;
      tick(5);

      // 1. Bounce on key0, then a clean press
      for (int i = 0; i < 10; i++) begin
         keys_raw[0] = ~keys_raw[0];
         tick(3);
      end
      chk("t1_bounce_stable", keys_stable, 2'b00);
      keys_raw[0] = 1'b0;
      tick(9);
      chk("t1_stable_edge9", keys_stable, 2'b00);
      tick(1);
      chk("t1_stable_edge10", keys_stable, 2'b01);

      // 2. Short press on key0
      tick(10);
      keys_raw[0] = 1'b1;
      tick(9);
      chk("t2_still_pressed", keys_stable, 2'b01);
      tick(1);
      chk("t2_stable_fall", keys_stable, 2'b00);
      chk("t2_short_not_yet", short_pending, 2'b00);
      tick(1);
      chk("t2_short_set", short_pending, 2'b01);
      chk("t2_no_long", long_pending, 2'b00);
      event_ack = 2'b01;
      tick(1);
      event_ack = 2'b00;
      chk("t2_short_acked", short_pending, 2'b00);

      // 3. Long press on key1
      keys_raw[1] = 1'b0;
      tick(10);
      chk("t3_stable_rise", keys_stable, 2'b10);
      tick(31);
      chk("t3_long_not_yet", long_pending, 2'b00);
      tick(1);
      chk("t3_long_set", long_pending, 2'b10);
      tick(18);
      keys_raw[1] = 1'b1;
      tick(12);
      chk("t3_no_short", short_pending, 2'b00);
      chk("t3_long_sticky", long_pending, 2'b10);
      event_ack = 2'b10;
      tick(1);
      event_ack = 2'b00;
      chk("t3_long_acked", long_pending, 2'b00);

      // 4. Ack collides with the short-press set
      keys_raw[0] = 1'b0;
      tick(15);
      keys_raw[0] = 1'b1;
      tick(10);
      chk("t4_stable_fall", keys_stable, 2'b00);
      event_ack = 2'b01;
      tick(1);
      event_ack = 2'b00;
      chk("t4_set_wins", short_pending, 2'b01);
      event_ack = 2'b01;
      tick(1);
      event_ack = 2'b00;
      chk("t4_second_ack", short_pending, 2'b00);

      // 5. Reset while key0 is in a long hold
      keys_raw[0] = 1'b0;
      tick(42);
      chk("t5_long_before_rst", long_pending, 2'b01);
      tick(5);
      nReset = 1'b0;
      #2;
      chk("t5_rst_stable", keys_stable, 2'b00);
      chk("t5_rst_long", long_pending, 2'b00);
      chk("t5_rst_short", short_pending, 2'b00);
      chk("t5_rst_repeat", repeat_pulse, 2'b00);
      tick(3);
      nReset = 1'b1;
      tick(9);
      chk("t5_stable_edge9", keys_stable, 2'b00);
      tick(1);
      chk("t5_stable_edge10", keys_stable, 2'b01);
      tick(31);
      chk("t5_long_not_yet", long_pending, 2'b00);
      tick(1);
      chk("t5_long_set", long_pending, 2'b01);

      // 6. Auto-repeat cadence while key0 stays held
      for (int p = 0; p < 3; p++) begin
         tick(15);
         chk("t6_repeat_gap", repeat_pulse, 2'b00);
         tick(1);
         chk("t6_repeat_slot", repeat_pulse, REP_EN ? 2'b01 : 2'b00);
      end
      tick(1);
      chk("t6_repeat_one_cycle", repeat_pulse, 2'b00);
      keys_raw[0] = 1'b1;
      tick(12);
      event_ack = 2'b01;
      tick(1);
      event_ack = 2'b00;

      // Random key activity, acks and one mid-run reset
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < NK; k++) begin
            if ($urandom_range(0, 99) < ((i < 1500) ? 4 : 1)) keys_raw[k] = ~keys_raw[k];
            event_ack[k] = ($urandom_range(0, 15) == 0);
         end
         if (i == 2200) nReset = 1'b0;
         if (i == 2203) nReset = 1'b1;
         tick(1);
      end
      event_ack = 2'b00;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
